// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch/sequencer.
//   FU_PC_W      : PC / instruction-memory word-address width used by the
//                  fetch unit and the decoder (branch address / pc fields).
//   FU_INSTR_W   : instruction word width.
//   fetch_state_e: fetch sequencer states.
package fetch_unit_pkg;

   localparam int unsigned FU_PC_W    = 19;
   localparam int unsigned FU_INSTR_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_HALTED
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch/sequencer for the multicycle core. Owns the PC, reads
//   instruction memory, issues instr/pc to the decoder with a one-cycle
//   decode_en pulse, then waits for the retire handshake (done). The next
//   PC is pc+1 or the redirect target.
// Ports
//   clk, rstn     : clock, synchronous active-low reset
//   start         : begin/resume fetching (only in IDLE or HALTED)
//   halt_req      : with done, stop after the current instruction
//   imem_addr     : instruction-memory word address (always the current pc)
//   imem_rdata    : instruction word, IMEM_LAT cycles after the address is sampled
//   decode_en     : one-cycle pulse, instr/pc valid for the decoder
//   instr, pc     : issued instruction and its word address
//   done          : current instruction retired (honoured only in WAIT)
//   redirect      : with done, next pc = redirect_pc
//   redirect_pc   : branch/bclr target word address
//   busy          : high in FETCH, ISSUE and WAIT
//   retired       : retired-instruction count, wraps at 2^32
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     PC_W     = FU_PC_W,
   parameter int unsigned     IMEM_LAT = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  halt_req,
   output logic [PC_W-1:0]       imem_addr,
   input  logic [FU_INSTR_W-1:0] imem_rdata,
   output logic                  decode_en,
   output logic [FU_INSTR_W-1:0] instr,
   output logic [PC_W-1:0]       pc,
   input  logic                  done,
   input  logic                  redirect,
   input  logic [PC_W-1:0]       redirect_pc,
   output logic                  busy,
   output logic [31:0]           retired
);

   localparam int unsigned     LAT_W    = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(IMEM_LAT - 1);

   fetch_state_e          state_q, state_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic [FU_INSTR_W-1:0] instr_q, instr_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic                  dec_q, dec_d;
   logic [31:0]           ret_q, ret_d;
   logic                  bubble_q, bubble_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         lat_q    <= '0;
         dec_q    <= 1'b0;
         ret_q    <= '0;
         bubble_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         lat_q    <= lat_d;
         dec_q    <= dec_d;
         ret_q    <= ret_d;
         bubble_q <= bubble_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      lat_d    = lat_q;
      dec_d    = 1'b0;
      ret_d    = ret_q;
      bubble_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               state_d = ST_FETCH;
               lat_d   = '0;
            end
         end
         ST_FETCH: begin
            // After a retire the new pc reaches the memory one edge later than
            // the FETCH entry, so the first FETCH cycle is spent letting the
            // memory sample it; from IDLE/HALTED the address is already stable.
            if (!bubble_q) begin
               if (lat_q == LAT_LAST) begin
                  instr_d = imem_rdata;
                  dec_d   = 1'b1;
                  lat_d   = '0;
                  state_d = ST_ISSUE;
               end else begin
                  lat_d = lat_q + 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (done) begin
               ret_d = ret_q + 32'd1;
               pc_d  = redirect ? redirect_pc : pc_q + 1'b1;
               lat_d = '0;
               if (halt_req) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d  = ST_FETCH;
                  bubble_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign decode_en = dec_q;
   assign retired   = ret_q;
   assign busy      = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A latency-pipelined memory model
//   feeds imem_rdata; a cycle-scheduled reference model predicts every
//   output each cycle; a short directed sequence pins literal values,
//   followed by randomized stimulus.
module tb_fetch_unit;

   localparam int LAT = 2;

   logic        clk;
   logic        rstn, start, halt_req, done, redirect;
   logic [18:0] redirect_pc;
   logic [18:0] imem_addr, pc;
   logic [31:0] imem_rdata, instr, retired;
   logic        decode_en, busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model state (values visible during cycle cyc)
   logic        m_busy, m_wait;
   logic [18:0] m_pc;
   logic [31:0] m_ret, m_instr;
   int          m_issue;

   fetch_unit #(.PC_W(19), .IMEM_LAT(LAT), .RESET_PC(19'h0)) dut (
      .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .decode_en(decode_en),
      .instr(instr), .pc(pc), .done(done), .redirect(redirect),
      .redirect_pc(redirect_pc), .busy(busy), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [18:0] a);
      if (a == 19'h0) return 32'h38600005;
      if (a == 19'h1) return 32'h7C632214;
      return {a[12:0], a} ^ 32'hA5C30F69;
   endfunction

   // memory samples the address each edge; data usable LAT edges later
   logic [18:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= imem_addr;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign imem_rdata = memf(pipe[LAT-1]);

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, got, exp);
      end
   endfunction

   function automatic void model_reset();
      m_busy  = 1'b0;
      m_wait  = 1'b0;
      m_pc    = 19'h0;
      m_ret   = 32'd0;
      m_instr = 32'd0;
      m_issue = -1;
   endfunction

   // advance model across the edge ending cycle cyc
   function automatic void model_step(input logic r, s, h, d, rd, input logic [18:0] rp);
      logic issuing;
      if (!r) begin
         model_reset();
      end else begin
         issuing = (m_issue == cyc);
         if (!m_busy && s) begin
            m_busy  = 1'b1;
            m_issue = cyc + LAT + 1;
         end else if (m_wait && d) begin
            m_ret  = m_ret + 32'd1;
            m_pc   = rd ? rp : m_pc + 19'd1;
            m_wait = 1'b0;
            if (h) begin
               m_busy  = 1'b0;
               m_issue = -1;
            end else begin
               m_issue = cyc + LAT + 2;
            end
         end
         if (issuing) m_wait = 1'b1;
         if (m_issue == cyc + 1) m_instr = memf(m_pc);
      end
   endfunction

   task automatic compare();
      chk("decode_en", {31'd0, decode_en}, {31'd0, (m_issue == cyc)});
      chk("busy",      {31'd0, busy},      {31'd0, m_busy});
      chk("pc",        {13'd0, pc},        {13'd0, m_pc});
      chk("imem_addr", {13'd0, imem_addr}, {13'd0, m_pc});
      chk("instr",     instr,              m_instr);
      chk("retired",   retired,            m_ret);
   endtask

   task automatic tick(input logic r, s, h, d, rd, input logic [18:0] rp);
      rstn = r; start = s; halt_req = h; done = d; redirect = rd; redirect_pc = rp;
      model_step(r, s, h, d, rd, rp);
      @(negedge clk);
      cyc++;
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
   endtask

   initial begin
      logic r, s, h, d, rd;
      logic [18:0] rp;
      rstn = 1'b0; start = 1'b0; halt_req = 1'b0; done = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      chk("rst_pc", {13'd0, pc}, 32'd0);
      chk("rst_dec", {31'd0, decode_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_retired", retired, 32'd0);

      idle(1);                                      // A: first cycle after release
      chk("rel_addr", {13'd0, imem_addr}, 32'd0);
      tick(1, 1, 0, 0, 0, 19'h0);                   // start -> A+1
      chk("f1_addr", {13'd0, imem_addr}, 32'd0);
      chk("f1_dec", {31'd0, decode_en}, 32'd0);
      idle(1);                                      // A+2
      chk("f2_dec", {31'd0, decode_en}, 32'd0);
      idle(1);                                      // A+3
      chk("iss0_dec", {31'd0, decode_en}, 32'd1);
      chk("iss0_instr", instr, 32'h38600005);
      chk("iss0_pc", {13'd0, pc}, 32'd0);
      idle(4);                                      // A+7
      tick(1, 0, 0, 1, 0, 19'h0);                   // done -> A+8
      chk("ret1", retired, 32'd1);
      tick(1, 0, 0, 1, 0, 19'h0);                   // done in FETCH -> A+9
      tick(1, 0, 0, 1, 0, 19'h0);                   // done in FETCH -> A+10
      idle(1);                                      // A+11
      chk("iss1_dec", {31'd0, decode_en}, 32'd1);
      chk("iss1_pc", {13'd0, pc}, 32'd1);
      chk("iss1_instr", instr, 32'h7C632214);
      chk("iss1_ret", retired, 32'd1);
      tick(1, 0, 0, 1, 0, 19'h0);                   // done in ISSUE -> A+12
      chk("issue_done_ret", retired, 32'd1);
      tick(1, 0, 1, 0, 1, 19'h00100);               // redirect/halt without done -> A+13
      chk("nodone_pc", {13'd0, pc}, 32'd1);
      chk("nodone_busy", {31'd0, busy}, 32'd1);
      tick(1, 0, 0, 1, 1, 19'h00100);               // redirect -> A+14
      idle(3);                                      // A+17
      chk("redir_dec", {31'd0, decode_en}, 32'd1);
      chk("redir_pc", {13'd0, pc}, 32'h100);
      chk("redir_instr", instr, memf(19'h00100));
      idle(1);                                      // A+18
      tick(1, 0, 0, 1, 1, 19'h7FFFF);               // -> A+19
      idle(3);                                      // A+22
      chk("top_pc", {13'd0, pc}, 32'h7FFFF);
      idle(1);                                      // A+23
      tick(1, 0, 0, 1, 0, 19'h0);                   // wrap -> A+24
      chk("wrap_pc", {13'd0, pc}, 32'd0);
      idle(3);                                      // A+27
      chk("wrap_dec", {31'd0, decode_en}, 32'd1);
      idle(1);                                      // A+28
      tick(1, 0, 1, 1, 0, 19'h0);                   // halt -> A+29
      chk("halt_busy", {31'd0, busy}, 32'd0);
      chk("halt_pc", {13'd0, pc}, 32'd1);
      chk("halt_ret", retired, 32'd5);
      idle(1);                                      // A+30
      tick(1, 1, 0, 0, 0, 19'h0);                   // resume -> A+31
      tick(1, 1, 0, 0, 0, 19'h0);                   // start while busy -> A+32
      idle(1);                                      // A+33
      chk("resume_dec", {31'd0, decode_en}, 32'd1);
      chk("resume_pc", {13'd0, pc}, 32'd1);
      chk("resume_instr", instr, 32'h7C632214);
      idle(1);                                      // A+34, WAIT
      tick(0, 0, 0, 0, 0, 19'h0);                   // reset in WAIT -> A+35
      chk("wrst_pc", {13'd0, pc}, 32'd0);
      chk("wrst_busy", {31'd0, busy}, 32'd0);
      chk("wrst_ret", retired, 32'd0);
      idle(6);

      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 199) != 0);
         s  = ($urandom_range(0, 3) == 0);
         h  = ($urandom_range(0, 7) == 0);
         d  = ($urandom_range(0, 2) == 0);
         rd = ($urandom_range(0, 1) == 0);
         rp = ($urandom_range(0, 3) == 0) ? 19'h7FFFF - 19'($urandom_range(0, 2))
                                          : 19'($urandom);
         tick(r, s, h, d, rd, rp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
